// File: rtl/simplez_pkg.sv
// Shared definitions for the Simplez core: opcode constants, FSM and ALU
// encodings, and the width relationship between address and data.
package simplez_pkg;

  localparam logic [2:0] CO_ST   = 3'd0;
  localparam logic [2:0] CO_LD   = 3'd1;
  localparam logic [2:0] CO_ADD  = 3'd2;
  localparam logic [2:0] CO_BR   = 3'd3;
  localparam logic [2:0] CO_BZ   = 3'd4;
  localparam logic [2:0] CO_CLR  = 3'd5;
  localparam logic [2:0] CO_DEC  = 3'd6;
  localparam logic [2:0] CO_HALT = 3'd7;

  localparam logic [3:0] COE_HALT = 4'hE;
  localparam logic [3:0] COE_WAIT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WAITT,
    S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_CLR,
    ALU_ADD,
    ALU_DEC
  } alu_op_t;

  // The instruction word is a 3-bit opcode followed by an address field.
  function automatic bit widths_ok(input int aw, input int dw);
    return dw == aw + 3;
  endfunction

endpackage

// File: rtl/simplez_alu.sv
// Combinational accumulator datapath: pass-through load, clear, add and
// decrement, with a zero flag on the result.
module simplez_alu
  import simplez_pkg::*;
#(
  parameter int DW = 12
) (
  input  alu_op_t         i_op,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [DW-1:0]   o_result,
  output logic            o_zero
);

  always_comb begin
    o_result = i_a;
    case (i_op)
      ALU_PASS: o_result = i_b;
      ALU_CLR:  o_result = '0;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_DEC:  o_result = i_a - DW'(1);
      default:  o_result = i_a;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/simplez_core.sv
// Simplez accumulator CPU with a single req/ack memory bus, HALT/resume and
// a programmable WAIT delay; retire pulses once per completed instruction.
module simplez_core
  import simplez_pkg::*;
#(
  parameter int AW          = 9,
  parameter int DW          = 12,
  parameter int WAIT_CYCLES = 2400000,
  parameter int RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          resume,
  output logic [DW-1:0] acc,
  output logic          zflag,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic          retire
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  if (!widths_ok(AW, DW)) begin : g_width_err
    $error("simplez_core: DW must equal AW+3");
  end
  if (WAIT_CYCLES < 1) begin : g_wait_err
    $error("simplez_core: WAIT_CYCLES must be at least 1");
  end

  state_t        r_state;
  logic [AW-1:0] r_cp;
  logic [DW-1:0] r_acc;
  logic          r_z;
  logic [DW-1:0] r_ri;
  logic [CW-1:0] r_wcnt;
  logic          r_retire;
  logic          r_halted;
  logic          r_run;

  logic [2:0]    w_co;
  logic [3:0]    w_coe;
  logic [AW-1:0] w_cd;
  logic          w_req;
  logic          w_xfer;
  alu_op_t       w_alu_op;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_zero;

  assign w_co  = r_ri[DW-1:DW-3];
  assign w_coe = r_ri[DW-1:DW-4];
  assign w_cd  = r_ri[AW-1:0];

  // r_run keeps the bus quiet until rstn has been sampled high once.
  assign w_req  = rstn && r_run && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign w_xfer = w_req && mem_ack;

  assign mem_req   = w_req;
  assign mem_we    = (r_state == S_MEM) && (w_co == CO_ST);
  assign mem_addr  = (r_state == S_MEM) ? w_cd : r_cp;
  assign mem_wdata = r_acc;

  assign acc    = r_acc;
  assign zflag  = r_z;
  assign halted = r_halted;
  assign pc     = r_cp;
  assign retire = r_retire;

  always_comb begin
    w_alu_op = ALU_PASS;
    if (r_state == S_EXEC) begin
      w_alu_op = (w_co == CO_CLR) ? ALU_CLR : ALU_DEC;
    end else if (w_co == CO_ADD) begin
      w_alu_op = ALU_ADD;
    end
  end

  simplez_alu #(.DW(DW)) u_alu (
    .i_op     (w_alu_op),
    .i_a      (r_acc),
    .i_b      (mem_rdata),
    .o_result (w_alu_res),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_FETCH;
      r_cp     <= AW'(RESET_PC);
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_ri     <= '0;
      r_wcnt   <= '0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_xfer) begin
            r_ri    <= mem_rdata;
            r_cp    <= r_cp + AW'(1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state  <= S_FETCH;
          r_retire <= 1'b1;
          case (w_co)
            CO_CLR, CO_DEC: begin
              r_acc <= w_alu_res;
              r_z   <= w_alu_zero;
            end
            CO_BR: r_cp <= w_cd;
            CO_BZ: if (r_z) r_cp <= w_cd;
            CO_ST, CO_LD, CO_ADD: begin
              r_state  <= S_MEM;
              r_retire <= 1'b0;
            end
            default: begin
              r_retire <= 1'b0;
              if (w_coe == COE_WAIT) begin
                r_wcnt  <= '0;
                r_state <= S_WAITT;
              end else begin
                r_halted <= 1'b1;
                r_state  <= S_HALTED;
              end
            end
          endcase
        end
        S_MEM: begin
          if (w_xfer) begin
            if (w_co != CO_ST) begin
              r_acc <= w_alu_res;
              r_z   <= w_alu_zero;
            end
            r_retire <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_WAITT: begin
          if (r_wcnt == CW'(WAIT_CYCLES - 1)) begin
            r_retire <= 1'b1;
            r_state  <= S_FETCH;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        S_HALTED: begin
          if (resume) begin
            r_halted <= 1'b0;
            r_retire <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
